// File: rtl/step_pkg.sv
// Shared types and helpers for the step clock controller.
//   step_state_e   : controller FSM states
//   cnt_width()    : counter width able to hold 0..n-1 (at least 1 bit)
//   *_SYNC_RESET   : reset levels of the input synchronizers
package step_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STEP,
        S_HOLD,
        S_RUN
    } step_state_e;

    // Key is active-low, so "released" is a high level.
    localparam logic KEY_SYNC_RESET = 1'b1;
    localparam logic RUN_SYNC_RESET = 1'b0;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/step_clock_ctrl_if.sv
// Signal bundle between the board inputs/outputs and the step clock controller.
//   key_n_i      : raw step push-button, active-low, asynchronous
//   run_i        : raw run/step mode switch, asynchronous (1 = free run)
//   step_en_o    : one-cycle clock enable to the core
//   pressed_o    : debounced button level (1 = pressed)
//   run_o        : debounced mode level
//   step_count_o : wrapping count of issued enables
// master drives the raw inputs, slave is the controller.
interface step_clock_ctrl_if #(
    parameter int unsigned CNT_W = 24
) ();

    logic             key_n_i;
    logic             run_i;
    logic             step_en_o;
    logic             pressed_o;
    logic             run_o;
    logic [CNT_W-1:0] step_count_o;

    modport master (
        output key_n_i,
        output run_i,
        input  step_en_o,
        input  pressed_o,
        input  run_o,
        input  step_count_o
    );

    modport slave (
        input  key_n_i,
        input  run_i,
        output step_en_o,
        output pressed_o,
        output run_o,
        output step_count_o
    );

endinterface

// File: rtl/sync_debounce.sv
// Two-flop synchronizer followed by a counter debouncer.
//   clk    : board clock
//   reset  : asynchronous, active-high
//   din_i  : raw asynchronous input
//   stb_o  : debounced stable level
// A change is accepted only after the synchronized input has differed from
// the stable value for DEBOUNCE_CYCLES consecutive cycles.
module sync_debounce
    import step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din_i,
    output logic stb_o
);

    localparam int unsigned   CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          stb_q;
    logic          stb_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            stb_q   <= RESET_VAL;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            stb_q   <= stb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        stb_d = stb_q;
        cnt_d = '0;
        if (sync2_q != stb_q) begin
            // Accept on the last differing cycle; counter clears either way.
            if (cnt_q == CNT_MAX) begin
                stb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign stb_o = stb_q;

endmodule

// File: rtl/step_clock_ctrl.sv
// Clock-enable generator for the soft core, running on the 50 MHz clock.
//   clk   : 50 MHz board clock
//   reset : asynchronous, active-high
//   bus   : slave side of step_clock_ctrl_if (raw key/run in; enable,
//           debounced levels and enable count out)
// Single-step mode emits one enable per debounced press; run mode emits an
// enable every RUN_DIV cycles.
module step_clock_ctrl
    import step_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned RUN_DIV         = 1,
    parameter int unsigned CNT_W           = 24
) (
    input  logic               clk,
    input  logic               reset,
    step_clock_ctrl_if.slave   bus
);

    localparam int unsigned   DW      = cnt_width(RUN_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(RUN_DIV - 1);

    logic             stb_key;
    logic             stb_run;
    logic             pressed;
    logic             run_lvl;
    logic             pressed_q;
    logic             press_rise;
    logic             step_en;
    step_state_e      state_q;
    step_state_e      state_d;
    logic [DW-1:0]    div_q;
    logic [DW-1:0]    div_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (KEY_SYNC_RESET)
    ) u_key_db (
        .clk   (clk),
        .reset (reset),
        .din_i (bus.key_n_i),
        .stb_o (stb_key)
    );

    sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RESET_VAL       (RUN_SYNC_RESET)
    ) u_run_db (
        .clk   (clk),
        .reset (reset),
        .din_i (bus.run_i),
        .stb_o (stb_run)
    );

    assign pressed    = ~stb_key;
    assign run_lvl    = stb_run;
    // pressed_q tracks the level in every state, so a press made while
    // running or held across leaving run mode never shows up as an edge.
    assign press_rise = pressed & ~pressed_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            count_q   <= '0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            count_q   <= count_d;
            pressed_q <= pressed;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        case (state_q)
            S_IDLE: begin
                div_d = '0;
                // Run takes priority over a simultaneous press edge.
                if (run_lvl) begin
                    state_d = S_RUN;
                end else if (press_rise) begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                state_d = S_HOLD;
            end
            S_HOLD: begin
                if (run_lvl) begin
                    state_d = S_RUN;
                end else if (!pressed) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!run_lvl) begin
                    state_d = S_IDLE;
                    div_d   = '0;
                end else if (div_q == DIV_MAX) begin
                    div_d = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                div_d   = '0;
            end
        endcase
    end

    // Decoded purely from registers: no combinational path from the inputs.
    assign step_en = (state_q == S_STEP) || ((state_q == S_RUN) && (div_q == DIV_MAX));

    always_comb begin
        count_d = count_q;
        if (step_en) begin
            count_d = count_q + 1'b1;
        end
    end

    assign bus.step_en_o    = step_en;
    assign bus.pressed_o    = pressed;
    assign bus.run_o        = run_lvl;
    assign bus.step_count_o = count_q;

endmodule

// File: tb/tb_step_clock_ctrl.sv
// Directed bench for step_clock_ctrl (DEBOUNCE_CYCLES=4, RUN_DIV=3).
// Cycle c is the interval after rising edge c; stimulus for cycle c is
// applied 1 time unit after that edge and outputs are checked on the
// following falling edge.
module tb_step_clock_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 3;

    logic clk = 1'b0;
    logic reset;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    step_clock_ctrl_if #(.CNT_W(8)) bus ();
    step_clock_ctrl_if #(.CNT_W(4)) bus_w ();

    step_clock_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .RUN_DIV         (RD),
        .CNT_W           (8)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    step_clock_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .RUN_DIV         (RD),
        .CNT_W           (4)
    ) u_dut_w (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_w)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Run-mode pulses: run_o rises in cycle 6, S_RUN from cycle 7, so the
    // divider hits RUN_DIV-1 in cycle 9 and every third cycle after.
    function automatic logic run_pulse(input int c, input int last);
        return (c >= 9) && (c <= last) && (((c - 9) % 3) == 0);
    endfunction

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        bus.key_n_i   = 1'b1;
        bus.run_i     = 1'b0;
        bus_w.key_n_i = 1'b1;
        bus_w.run_i   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst step_en", 32'(bus.step_en_o), 0);
        check("rst pressed", 32'(bus.pressed_o), 0);
        check("rst run_o", 32'(bus.run_o), 0);
        check("rst count", 32'(bus.step_count_o), 0);
        check("rst count_w", 32'(bus_w.step_count_o), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle_cycles(5);

        // Clean press held 40 cycles
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) bus.key_n_i = 1'b0;
            @(negedge clk);
            check($sformatf("clean step_en c=%0d", c), 32'(bus.step_en_o), 32'(c == 7));
            check($sformatf("clean pressed c=%0d", c), 32'(bus.pressed_o), 32'(c >= 6));
        end
        check("clean count", 32'(bus.step_count_o), 1);
        bus.key_n_i = 1'b1;
        idle_cycles(20);
        check("clean released", 32'(bus.pressed_o), 0);

        // Bounce: low 3, high 2, then low and held
        for (int c = 0; c < 31; c++) begin
            @(posedge clk);
            #1;
            bus.key_n_i = (c < 3) ? 1'b0 : (c < 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            check($sformatf("bounce step_en c=%0d", c), 32'(bus.step_en_o), 32'(c == 12));
            check($sformatf("bounce pressed c=%0d", c), 32'(bus.pressed_o), 32'(c >= 11));
        end
        check("bounce count", 32'(bus.step_count_o), 2);
        bus.key_n_i = 1'b1;
        idle_cycles(20);

        // Run mode: run_i high at cycle 0, dropped at cycle 39
        for (int c = 0; c < 56; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) bus.run_i = 1'b1;
            if (c == 39) bus.run_i = 1'b0;
            @(negedge clk);
            check($sformatf("run step_en c=%0d", c), 32'(bus.step_en_o), 32'(run_pulse(c, 45)));
            check($sformatf("run run_o c=%0d", c), 32'(bus.run_o), 32'((c >= 6) && (c <= 44)));
            if (c == 38) check("run count10", 32'(bus.step_count_o), 12);
        end
        check("run count", 32'(bus.step_count_o), 15);
        check("run div", 32'(u_dut.div_q), 0);

        // Press and release while running, then leave run mode
        for (int c = 0; c < 81; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) bus.run_i = 1'b1;
            if (c == 15) bus.key_n_i = 1'b0;
            if (c == 30) bus.key_n_i = 1'b1;
            if (c == 40) bus.run_i = 1'b0;
            @(negedge clk);
            check($sformatf("prun step_en c=%0d", c), 32'(bus.step_en_o), 32'(run_pulse(c, 45)));
            check($sformatf("prun pressed c=%0d", c), 32'(bus.pressed_o),
                  32'((c >= 21) && (c < 36)));
        end
        check("prun count", 32'(bus.step_count_o), 28);

        // Wrap on the 4-bit counter instance: 17 steps end at 1
        for (int s = 1; s <= 17; s++) begin
            for (int c = 0; c < 24; c++) begin
                @(posedge clk);
                #1;
                bus_w.key_n_i = (c < 12) ? 1'b0 : 1'b1;
                @(negedge clk);
                check($sformatf("wrap step_en s=%0d c=%0d", s, c), 32'(bus_w.step_en_o),
                      32'(c == 7));
            end
            check($sformatf("wrap count s=%0d", s), 32'(bus_w.step_count_o), 32'(s % 16));
        end

        // Reset mid-debounce with the key held through release
        for (int c = 0; c < 31; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) bus.key_n_i = 1'b0;
            if (c == 4) reset = 1'b1;
            if (c == 10) reset = 1'b0;
            @(negedge clk);
            check($sformatf("mrst step_en c=%0d", c), 32'(bus.step_en_o), 32'(c == 17));
            check($sformatf("mrst pressed c=%0d", c), 32'(bus.pressed_o), 32'(c >= 16));
            check($sformatf("mrst run_o c=%0d", c), 32'(bus.run_o), 0);
            if (c == 3) check("mrst count before", 32'(bus.step_count_o), 28);
            if ((c >= 4) && (c <= 9)) begin
                check($sformatf("mrst count c=%0d", c), 32'(bus.step_count_o), 0);
            end
            if (c == 5) check("mrst count_w", 32'(bus_w.step_count_o), 0);
        end
        check("mrst count after", 32'(bus.step_count_o), 1);
        bus.key_n_i = 1'b1;
        idle_cycles(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
